// File: rtl/pipe_hazard_ctrl.sv
// Central pipeline controller: memory wait-state sequencing, RAW hazard stalls,
// branch squashes and a saturating stall-cycle counter.
`timescale 1ns/1ps
module pipe_hazard_ctrl #(
    parameter int MEM_WAIT = 6,
    parameter int FWD_EN   = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  id_src1,
    input  logic [3:0]  id_src2,
    input  logic        id_use_src1,
    input  logic        id_two_src,
    input  logic [3:0]  exe_dest,
    input  logic        exe_wb_en,
    input  logic        exe_mem_r_en,
    input  logic [3:0]  mem_dest,
    input  logic        mem_wb_en,
    input  logic        mem_req,
    input  logic        exe_b,
    output logic        freeze_pc,
    output logic        freeze_if_reg,
    output logic        flush_if_reg,
    output logic        freeze_id_reg,
    output logic        flush_id_reg,
    output logic        freeze_exe_reg,
    output logic        freeze_mem_reg,
    output logic        mem_stall,
    output logic        hazard,
    output logic [15:0] stall_cycles
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_e;

    // IDLE and DONE each take one cycle, so BUSY covers the remaining MEM_WAIT-2.
    localparam logic [3:0] WCNT_LOAD = 4'(MEM_WAIT - 3);

    mem_state_e  state_q, state_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic [15:0] stall_q, stall_d;

    logic haz_fwd;
    logic haz_nofwd;
    logic src1_raw;
    logic src2_raw;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            wcnt_q  <= 4'd0;
            stall_q <= 16'd0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            stall_q <= stall_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            IDLE: begin
                if (mem_req) begin
                    state_d = BUSY;
                    wcnt_d  = WCNT_LOAD;
                end
            end
            BUSY: begin
                if (wcnt_q == 4'd0) begin
                    state_d = DONE;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            // The finishing instruction still drives mem_req here, so it is ignored.
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                wcnt_d  = 4'd0;
            end
        endcase
    end

    always_comb begin
        src1_raw  = (exe_wb_en && (exe_dest == id_src1)) ||
                    (mem_wb_en && (mem_dest == id_src1));
        src2_raw  = (exe_wb_en && (exe_dest == id_src2)) ||
                    (mem_wb_en && (mem_dest == id_src2));
        haz_nofwd = (id_use_src1 && src1_raw) || (id_two_src && src2_raw);
        // With forwarding only a load in EXE cannot supply its result in time.
        haz_fwd   = exe_wb_en && exe_mem_r_en &&
                    ((id_use_src1 && (exe_dest == id_src1)) ||
                     (id_two_src  && (exe_dest == id_src2)));
        hazard    = (FWD_EN != 0) ? haz_fwd : haz_nofwd;
    end

    always_comb begin
        mem_stall      = ((state_q == IDLE) && mem_req) || (state_q == BUSY);
        freeze_pc      = 1'b0;
        freeze_if_reg  = 1'b0;
        flush_if_reg   = 1'b0;
        freeze_id_reg  = 1'b0;
        flush_id_reg   = 1'b0;
        freeze_exe_reg = 1'b0;
        freeze_mem_reg = 1'b0;
        if (mem_stall) begin
            freeze_pc      = 1'b1;
            freeze_if_reg  = 1'b1;
            freeze_id_reg  = 1'b1;
            freeze_exe_reg = 1'b1;
            freeze_mem_reg = 1'b1;
        end else if (exe_b) begin
            flush_if_reg = 1'b1;
            flush_id_reg = 1'b1;
        end else if (hazard) begin
            freeze_pc     = 1'b1;
            freeze_if_reg = 1'b1;
            flush_id_reg  = 1'b1;
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (freeze_pc && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized and directed bench for pipe_hazard_ctrl: two instances (no forwarding,
// MEM_WAIT=6; forwarding, MEM_WAIT=3) checked against an occupancy-based reference model.
`timescale 1ns/1ps
module tb_pipe_hazard_ctrl;

    localparam int NDUT = 2;
    localparam int MW0  = 6;
    localparam int MW1  = 3;

    logic clk = 1'b0;
    logic rst;
    logic [3:0] id_src1, id_src2, exe_dest, mem_dest;
    logic id_use_src1, id_two_src, exe_wb_en, exe_mem_r_en, mem_wb_en, mem_req, exe_b;

    logic [1:0] fpc, fif, flif, fid, flid, fexe, fmem, ms, hz;
    logic [15:0] sc0, sc1;

    int vectors = 0;
    int miscompares = 0;

    int mw [NDUT];
    int fwd [NDUT];
    int pos [NDUT];   // cycle index of the current access inside MEM, 0 = none
    int cnt [NDUT];

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MEM_WAIT(MW0), .FWD_EN(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .id_src1(id_src1), .id_src2(id_src2), .id_use_src1(id_use_src1), .id_two_src(id_two_src),
        .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .mem_req(mem_req), .exe_b(exe_b),
        .freeze_pc(fpc[0]), .freeze_if_reg(fif[0]), .flush_if_reg(flif[0]),
        .freeze_id_reg(fid[0]), .flush_id_reg(flid[0]), .freeze_exe_reg(fexe[0]),
        .freeze_mem_reg(fmem[0]), .mem_stall(ms[0]), .hazard(hz[0]), .stall_cycles(sc0)
    );

    pipe_hazard_ctrl #(.MEM_WAIT(MW1), .FWD_EN(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .id_src1(id_src1), .id_src2(id_src2), .id_use_src1(id_use_src1), .id_two_src(id_two_src),
        .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .mem_req(mem_req), .exe_b(exe_b),
        .freeze_pc(fpc[1]), .freeze_if_reg(fif[1]), .flush_if_reg(flif[1]),
        .freeze_id_reg(fid[1]), .flush_id_reg(flid[1]), .freeze_exe_reg(fexe[1]),
        .freeze_mem_reg(fmem[1]), .mem_stall(ms[1]), .hazard(hz[1]), .stall_cycles(sc1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] got_ctl(input int d);
        return {fpc[d], fif[d], flif[d], fid[d], flid[d], fexe[d], fmem[d], ms[d], hz[d]};
    endfunction

    function automatic logic [15:0] got_cnt(input int d);
        return (d == 0) ? sc0 : sc1;
    endfunction

    function automatic int cur_cycle(input int d);
        return (pos[d] == 0 && mem_req) ? 1 : pos[d];
    endfunction

    function automatic logic model_hazard(input int d);
        logic [3:0] src [2];
        logic       used [2];
        logic       h;
        src[0] = id_src1;  used[0] = id_use_src1;
        src[1] = id_src2;  used[1] = id_two_src;
        h = 1'b0;
        for (int s = 0; s < 2; s++) begin
            if (used[s]) begin
                if (fwd[d] != 0) begin
                    if (exe_wb_en && exe_mem_r_en && exe_dest == src[s]) h = 1'b1;
                end else begin
                    if (exe_wb_en && exe_dest == src[s]) h = 1'b1;
                    if (mem_wb_en && mem_dest == src[s]) h = 1'b1;
                end
            end
        end
        return h;
    endfunction

    // Order: freeze_pc, freeze_if, flush_if, freeze_id, flush_id, freeze_exe, freeze_mem, mem_stall, hazard
    function automatic logic [8:0] model_ctl(input int d);
        int   c;
        logic stall, h;
        c     = cur_cycle(d);
        stall = (c >= 1) && (c < mw[d]);
        h     = model_hazard(d);
        if (stall)      return {7'b1101011, 1'b1, h};
        else if (exe_b) return {7'b0010100, 1'b0, h};
        else if (h)     return {7'b1100100, 1'b0, h};
        else            return {7'b0000000, 1'b0, h};
    endfunction

    task automatic settle(input string tag);
        #1;
        for (int d = 0; d < NDUT; d++) begin
            if (rst) begin
                pos[d] = 0;
                cnt[d] = 0;
            end
            chk($sformatf("%s_ctl%0d", tag, d), 32'(got_ctl(d)), 32'(model_ctl(d)));
            chk($sformatf("%s_cnt%0d", tag, d), 32'(got_cnt(d)), 32'(cnt[d]));
        end
    endtask

    task automatic tick();
        int npos [NDUT];
        int ncnt [NDUT];
        for (int d = 0; d < NDUT; d++) begin
            int   c;
            logic [8:0] e;
            c = cur_cycle(d);
            e = model_ctl(d);
            npos[d] = (c == 0 || c == mw[d]) ? 0 : c + 1;
            ncnt[d] = (e[8] && cnt[d] < 65535) ? cnt[d] + 1 : cnt[d];
            if (rst) begin
                npos[d] = 0;
                ncnt[d] = 0;
            end
        end
        @(posedge clk);
        for (int d = 0; d < NDUT; d++) begin
            pos[d] = npos[d];
            cnt[d] = ncnt[d];
        end
        @(negedge clk);
    endtask

    task automatic step(input string tag);
        settle(tag);
        tick();
    endtask

    task automatic quiet();
        id_src1 = 0; id_src2 = 0; id_use_src1 = 0; id_two_src = 0;
        exe_dest = 0; exe_wb_en = 0; exe_mem_r_en = 0;
        mem_dest = 0; mem_wb_en = 0; mem_req = 0; exe_b = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step("reset");
        rst = 1'b0;
    endtask

    initial begin
        mw[0] = MW0; fwd[0] = 0;
        mw[1] = MW1; fwd[1] = 1;
        for (int d = 0; d < NDUT; d++) begin pos[d] = 0; cnt[d] = 0; end
        quiet();
        rst = 1'b1;
        @(negedge clk);

        // Reset state
        settle("rst");
        chk("rst_ctl0", 32'(got_ctl(0)), 32'd0);
        chk("rst_cnt0", 32'(sc0), 32'd0);
        chk("rst_cnt1", 32'(sc1), 32'd0);
        tick();
        rst = 1'b0;

        // Isolated load on MEM_WAIT=6: five stall cycles, then DONE
        mem_req = 1'b1;
        for (int i = 0; i < MW0; i++) begin
            settle("load");
            chk("load_ms0", 32'(ms[0]), 32'(i < MW0 - 1));
            chk("load_fmem0", 32'(fmem[0]), 32'(i < MW0 - 1));
            tick();
        end
        mem_req = 1'b0;
        settle("load_end");
        chk("load_cnt0", 32'(sc0), 32'd5);
        tick();
        repeat (4) step("drain");

        // Load-use with forwarding: one bubble; without a load, none
        exe_dest = 4'd3; exe_wb_en = 1; exe_mem_r_en = 1; id_src1 = 4'd3; id_use_src1 = 1;
        settle("ldu");
        chk("ldu_haz1", 32'(hz[1]), 32'd1);
        chk("ldu_fpc1", 32'({fpc[1], fif[1], flid[1], fid[1]}), 32'b1110);
        tick();
        exe_mem_r_en = 0;
        settle("noload");
        chk("noload_haz1", 32'(hz[1]), 32'd0);
        chk("noload_haz0", 32'(hz[0]), 32'd1);
        tick();
        quiet();

        // RAW against MEM on src2 without forwarding
        mem_dest = 4'd5; mem_wb_en = 1; id_two_src = 1; id_src2 = 4'd5; id_src1 = 4'd9;
        settle("raw2");
        chk("raw2_fpc0", 32'(fpc[0]), 32'd1);
        tick();
        id_two_src = 0;
        settle("raw2off");
        chk("raw2off_haz0", 32'(hz[0]), 32'd0);
        tick();

        // Branch wins over hazard
        id_two_src = 1; exe_b = 1;
        settle("brhaz");
        chk("brhaz_fl0", 32'({flif[0], flid[0], fpc[0]}), 32'b110);
        tick();
        quiet();

        // Branch during BUSY waits for DONE
        mem_req = 1'b1;
        step("brbusy_idle");
        exe_b = 1'b1;
        for (int i = 1; i < MW0; i++) begin
            settle("brbusy");
            chk("brbusy_flif0", 32'(flif[0]), 32'(i == MW0 - 1));
            chk("brbusy_fpc0", 32'(fpc[0]), 32'(i < MW0 - 1));
            tick();
        end
        quiet();
        repeat (4) step("drain2");

        // Back-to-back loads, reset in cycle 3 of the second
        mem_req = 1'b1;
        for (int i = 0; i < MW0 + 2; i++) step("b2b");
        rst = 1'b1;
        settle("b2b_rst");
        chk("b2b_rst_cnt0", 32'(sc0), 32'd0);
        tick();
        mem_req = 1'b0;
        settle("b2b_rel");
        chk("b2b_rel_ctl0", 32'(got_ctl(0)), 32'd0);
        tick();
        rst = 1'b0;
        mem_req = 1'b1;
        for (int i = 0; i < MW0; i++) step("b2b_fresh");
        quiet();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            id_src1      = 4'($urandom_range(0, 3));
            id_src2      = 4'($urandom_range(0, 3));
            exe_dest     = 4'($urandom_range(0, 3));
            mem_dest     = 4'($urandom_range(0, 3));
            id_use_src1  = 1'($urandom_range(0, 1));
            id_two_src   = 1'($urandom_range(0, 1));
            exe_wb_en    = 1'($urandom_range(0, 1));
            exe_mem_r_en = 1'($urandom_range(0, 1));
            mem_wb_en    = 1'($urandom_range(0, 1));
            mem_req      = ($urandom_range(0, 2) != 0);
            exe_b        = ($urandom_range(0, 7) == 0);
            rst          = ($urandom_range(0, 199) == 0);
            step("rnd");
        end
        rst = 1'b0;
        quiet();
        repeat (MW0 + 1) step("drain3");

        // Saturation: hold a load-use hazard long enough to wrap a 16-bit counter
        exe_dest = 4'd2; exe_wb_en = 1; exe_mem_r_en = 1; id_src1 = 4'd2; id_use_src1 = 1;
        repeat (65600) @(negedge clk);
        for (int d = 0; d < NDUT; d++) cnt[d] = 65535;
        settle("sat");
        chk("sat_cnt0", 32'(sc0), 32'h0000FFFF);
        chk("sat_cnt1", 32'(sc1), 32'h0000FFFF);
        tick();
        step("sat_hold");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central pipeline controller for the five-stage core. It owns every freeze/flush control of the IF, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It sequences three things:
- multi-cycle data-memory accesses, through a wait-state FSM;
- RAW data-hazard stalls, with or without forwarding;
- branch squashes.

It also keeps a saturating stall-cycle counter for performance debug.

## Interface
Parameters:
- MEM_WAIT, 6, total cycles a load/store occupies the MEM stage; legal range 3..16.
- FWD_EN, 0, 1 = forwarding unit present (stall only on load-use); 0 = stall on any RAW match.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- id_src1  in  4  Rn index of the instruction in ID.
- id_src2  in  4  Rm/Rd index of the instruction in ID.
- id_use_src1  in  1  ID instruction reads src1.
- id_two_src  in  1  ID instruction reads src2.
- exe_dest  in  4  destination of the instruction in EXE.
- exe_wb_en  in  1  EXE instruction writes the register file.
- exe_mem_r_en  in  1  EXE instruction is a load.
- mem_dest  in  4  destination of the instruction in MEM.
- mem_wb_en  in  1  MEM instruction writes the register file.
- mem_req  in  1  MEM instruction is a load or store (MEM_R_EN | MEM_W_EN).
- exe_b  in  1  branch taken, resolved in EXE.
- freeze_pc  out  1  hold PC.
- freeze_if_reg  out  1  hold IF/ID.
- flush_if_reg  out  1  clear IF/ID to a bubble.
- freeze_id_reg  out  1  hold ID/EX.
- flush_id_reg  out  1  clear ID/EX to a bubble.
- freeze_exe_reg  out  1  hold EX/MEM.
- freeze_mem_reg  out  1  hold MEM/WB.
- mem_stall  out  1  memory wait in progress.
- hazard  out  1  raw data-hazard detect, before priority masking.
- stall_cycles  out  16  saturating count of cycles with freeze_pc=1.

## Operation
Memory FSM states are IDLE, BUSY and DONE. A 4-bit wait counter `wcnt` belongs to the FSM.
- IDLE & mem_req: go to BUSY and load wcnt = MEM_WAIT-3.
- BUSY & wcnt==0: go to DONE. BUSY otherwise: decrement wcnt.
- DONE: go to IDLE unconditionally. mem_req is ignored in DONE, because the same instruction is still present that cycle.
- mem_stall = (IDLE & mem_req) | BUSY.

Hazard detection is combinational:
- FWD_EN=0: hazard = (id_use_src1 & ((exe_wb_en & exe_dest==id_src1) | (mem_wb_en & mem_dest==id_src1))) | (id_two_src & the same two terms on id_src2).
- FWD_EN=1: hazard = exe_wb_en & exe_mem_r_en & ((id_use_src1 & exe_dest==id_src1) | (id_two_src & exe_dest==id_src2)).

Control priority, highest first:
1. mem_stall=1
   - All five freezes = 1; both flushes = 0.
   - A pending branch or hazard waits; it is re-evaluated on release.
2. exe_b=1
   - flush_if_reg = 1, flush_id_reg = 1, all freezes = 0.
   - The PC loads the branch target. Hazard is ignored because the stalled instruction is squashed.
3. hazard=1
   - freeze_pc = 1, freeze_if_reg = 1, flush_id_reg = 1 (bubble into EXE).
   - freeze_id_reg, freeze_exe_reg and freeze_mem_reg = 0.
4. Otherwise all controls = 0.

stall_cycles increments on every clock edge with freeze_pc=1. It holds at 16'hFFFF.

## Timing
- Reset, asynchronous:
  - state = IDLE, wcnt = 0, stall_cycles = 0.
  - All outputs are 0 while rst is high, unless mem_req/hazard inputs are already asserted, since outputs are combinational.
  - Reset mid-access abandons the access; the next mem_req starts a fresh MEM_WAIT sequence.
- Outputs are combinational from state and inputs, valid in the same cycle. Only state, wcnt and stall_cycles are registered.
- Memory access cycle count:
  - The instruction occupies MEM for exactly MEM_WAIT cycles: 1 IDLE, MEM_WAIT-2 BUSY, 1 DONE.
  - mem_stall=1 for the first MEM_WAIT-1 of those cycles. The pipeline advances at the end of the DONE cycle.
- Back-to-back memory ops: after DONE the FSM enters IDLE. A new mem_req in that cycle starts the next sequence, so there is no idle gap.
- A load-use hazard costs exactly 1 bubble when FWD_EN=1. When FWD_EN=0, a RAW hazard costs up to 2 bubbles.

## Test plan
- MEM_WAIT=6: hold mem_req=1 for an isolated load → mem_stall=1 for 5 cycles, all freezes=1 on those 5 cycles, 0 on the 6th (DONE); stall_cycles=5.
- FWD_EN=1: exe_dest=3, exe_wb_en=1, exe_mem_r_en=1, id_src1=3, id_use_src1=1 → hazard=1, freeze_pc=1, freeze_if_reg=1, flush_id_reg=1 for 1 cycle. With exe_mem_r_en=0 → no stall.
- FWD_EN=0: mem_dest=5, mem_wb_en=1, id_two_src=1, id_src2=5 → stall asserted. With id_two_src=0 → none.
- exe_b=1 with hazard=1 in the same cycle → flush_if_reg=1, flush_id_reg=1, freeze_pc=0.
- exe_b=1 during BUSY → flushes stay 0 and all freezes stay 1 until the DONE cycle; flushes assert in DONE.
- Two consecutive loads, then rst pulsed in cycle 3 of the second → state IDLE, stall_cycles=0, outputs 0 once mem_req is dropped.
